// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache
// ----------------
// Data-cache controller for the MEM stage of the 16-bit pipelined CPU.
// Direct-mapped, 4 lines x 4 words x 16 bits, write-through, no-write-allocate.
// Address split: tag = addr[15:4], index = addr[3:2], word = addr[1:0].
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   req_read, req_write MEM-stage load / store request (store wins if both)
//   req_addr, req_wdata request word address and store data
//   rdata               load data (valid when req_read=1 and stall_mem=0)
//   stall_mem           combinational hold for the EX/MEM register
//   mem_read, mem_write line-fill / word-write request to backing memory
//   mem_addr, mem_wdata backing-memory address and store data
//   mem_rdata           64-bit fill line, word0 in [15:0]
//   mem_ready           one-cycle completion pulse from backing memory
//   access_count        completed requests (wraps)
//   hit_count           read hits that needed no fill (wraps)

module mem_stage_dcache (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [15:0] rdata,
    output logic        stall_mem,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] access_count,
    output logic [15:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Cache storage. Only the valid bits need a reset; tags and data are
    // ignored until their line is marked valid.
    logic [3:0]  valid;
    logic [11:0] tags  [4];
    logic [63:0] lines [4];

    // Set when the previous cycle was FILL, so the completion of a refilled
    // read is not counted as a hit.
    logic prev_fill;

    logic [11:0] req_tag;
    logic [1:0]  req_index;
    logic [1:0]  req_word;
    logic        hit;
    logic [15:0] hit_word;
    logic        access_done;
    logic        hit_done;

    assign req_tag   = req_addr[15:4];
    assign req_index = req_addr[3:2];
    assign req_word  = req_addr[1:0];

    assign hit      = valid[req_index] && (tags[req_index] == req_tag);
    assign hit_word = lines[req_index][{req_word, 4'b0000} +: 16];

    // Next-state and output decode.
    always_comb begin
        next_state = state;
        stall_mem  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rdata      = '0;

        case (state)
            IDLE: begin
                if (req_write) begin
                    stall_mem  = 1'b1;
                    next_state = WRITE;
                end else if (req_read) begin
                    if (hit) begin
                        rdata = hit_word;
                    end else begin
                        stall_mem  = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                stall_mem = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = {req_addr[15:2], 2'b00};
                if (mem_ready) begin
                    next_state = IDLE;
                end
            end
            WRITE: begin
                stall_mem = 1'b1;
                mem_write = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = req_wdata;
                if (mem_ready) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // While reset is held a pending miss must not stall the pipeline.
        if (!reset_n) begin
            stall_mem = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            rdata     = '0;
        end
    end

    assign access_done = (req_read || req_write) && !stall_mem;
    assign hit_done    = (state == IDLE) && req_read && !req_write && hit && !prev_fill;

    // Control state, valid bits and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            valid        <= '0;
            prev_fill    <= 1'b0;
            access_count <= '0;
            hit_count    <= '0;
        end else begin
            state     <= next_state;
            prev_fill <= (state == FILL);
            if ((state == FILL) && mem_ready) begin
                valid[req_index] <= 1'b1;
            end
            if (access_done) begin
                access_count <= access_count + 16'd1;
            end
            if (hit_done) begin
                hit_count <= hit_count + 16'd1;
            end
        end
    end

    // Tag and data arrays.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ready) begin
            tags[req_index]  <= req_tag;
            lines[req_index] <= mem_rdata;
        end else if ((state == WRITE) && mem_ready && hit) begin
            lines[req_index][{req_word, 4'b0000} +: 16] <= req_wdata;
        end
    end

endmodule

// File: doc/mem_stage_dcache.md
# mem_stage_dcache

Data-cache controller for the MEM stage of the cached 16-bit pipelined CPU. It consumes the memory request held in the EX/MEM pipeline register: address, store data and read/write control. It serves reads from a direct-mapped 4-line × 4-word cache and sends misses and all stores to slow backing memory. While an access is outstanding it drives `stall_mem` back to the EX/MEM register, which holds the request stable until the access completes.

## Interface
Parameters:
- none; geometry is fixed at 4 lines × 4 words × 16 bits.
- address split: tag = addr[15:4], index = addr[3:2], word = addr[1:0].

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read  in  1  MEM-stage load request.
- req_write  in  1  MEM-stage store request; wins if both request inputs are high.
- req_addr  in  16  word address; ALU result.
- req_wdata  in  16  store data; read_data2.
- rdata  out  16  load data; valid when req_read=1 and stall_mem=0.
- stall_mem  out  1  holds the EX/MEM register; combinational.
- mem_read  out  1  line-fill request to backing memory.
- mem_write  out  1  word-write request to backing memory.
- mem_addr  out  16  line base {addr[15:2],2'b00} for a fill; the full address for a write.
- mem_wdata  out  16  store data for a write.
- mem_rdata  in  64  fill line; word0 sits in [15:0].
- mem_ready  in  1  one-cycle completion pulse from backing memory.
- access_count  out  16  number of completed requests; wraps.
- hit_count  out  16  number of read hits that needed no fill; wraps.

## Operation
FSM states: IDLE, FILL, WRITE, DONE.

IDLE:
- No request: stall_mem=0.
- Read hit (valid[index] and tag match): stall_mem=0 and rdata=data[index][word] in the same cycle. Stay in IDLE.
- Read miss: stall_mem=1. Next state is FILL.
- Write (any): stall_mem=1. Next state is WRITE.

FILL:
- stall_mem=1, mem_read=1, mem_addr=line base.
- On mem_ready: load the line from mem_rdata, write the tag, set valid[index]=1, go to IDLE.
- Back in IDLE the held request now hits and completes.

WRITE:
- Write-through, no-write-allocate.
- stall_mem=1, mem_write=1, mem_addr=req_addr, mem_wdata=req_wdata.
- On mem_ready: if the address hits, update data[index][word]; a miss leaves the cache untouched. Go to DONE.

DONE:
- stall_mem=0 for exactly one cycle so the pipeline advances past the store. Then go to IDLE.

General rules:
- mem_read and mem_write are never high together.
- Both deassert in the same cycle that mem_ready is sampled.
- Requests are held stable by the pipeline while stall_mem=1. A change in request during FILL or WRITE is undefined.

Counters:
- access_count increments on each cycle with a request (req_read or req_write) and stall_mem=0.
- hit_count increments on a read completion in IDLE when the previous state was not FILL.

## Timing
- Read hit: 0 stall cycles; rdata is combinational.
- Read miss: stall_mem is high from the request cycle through the mem_ready cycle. Data is returned the cycle after mem_ready. Stall = memory latency + 1 cycles.
- Store: stall_mem is high from the request cycle through the mem_ready cycle. DONE follows, with stall_mem=0.
- mem_ready arriving in the first FILL/WRITE cycle is legal: 1-cycle memory.
- mem_ready while in IDLE or DONE is ignored.
- Reset (asynchronous, any state, including mid-FILL or mid-WRITE):
  - state=IDLE; all valid bits cleared; counters=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - stall_mem=0 and rdata=0 while reset_n is low.
- An aborted fill does not set valid.

## Test plan
- Reset, then read 0x0013 with 2-cycle memory returning 64'h0004_0003_0002_0001. Required: stall_mem high for 3 cycles, then rdata=0x0004; access_count=1, hit_count=0.
- Immediately read 0x0010, then 0x0012. Required: both complete with 0 stalls, rdata 0x0001 then 0x0003; hit_count=2.
- Write 0xBEEF to 0x0011 (hit). Required: mem_write with mem_addr=0x0011 and mem_wdata=0xBEEF until mem_ready, DONE cycle with stall_mem=0. A following read of 0x0011 hits and returns 0xBEEF.
- Write 0x1234 to 0x0051 (miss; index 0, tag differs). Required: memory write issued and cache unchanged; a read of 0x0011 still hits and returns 0xBEEF.
- Read 0x0050 (same index, new tag). Required: line evicted and refilled, stall_mem=1 until the fill completes. A later read of 0x0010 misses again.
- Assert reset_n=0 mid-FILL. Required: mem_read drops immediately and counters=0. After release, a read of 0x0010 misses.
